// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: collects credit, issues one datapath lookup/debit per selection,
// then sequences dispense, change return and the error light.
module vend_txn_controller #(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 15,
  parameter int IDLE_TO    = 1000,
  parameter int ACK_TO     = 64,
  parameter int ERR_HOLD   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [2:0]          sel_code,
  input  logic [3:0]          sel_qty,
  input  logic                cancel,
  output logic                dp_req,
  output logic [2:0]          dp_code,
  output logic [3:0]          dp_qty,
  output logic [CREDIT_W-1:0] dp_credit,
  input  logic                dp_ack,
  input  logic                dp_ok,
  input  logic [7:0]          dp_cost,
  output logic                dispense,
  output logic [2:0]          dispense_code,
  output logic [3:0]          dispense_qty,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  input  logic                change_taken,
  output logic [CREDIT_W-1:0] credit,
  output logic                red_light,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_REQ      = 3'd2,
    S_WAIT     = 3'd3,
    S_DISPENSE = 3'd4,
    S_CHANGE   = 3'd5,
    S_ERROR    = 3'd6
  } state_t;

  // One timer is shared by COLLECT, WAIT and ERROR since they are mutually exclusive.
  localparam int TMR_MAX0 = (IDLE_TO > ACK_TO) ? IDLE_TO : ACK_TO;
  localparam int TMR_MAX  = (TMR_MAX0 > ERR_HOLD) ? TMR_MAX0 : ERR_HOLD;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]    IDLE_LAST = TMR_W'(IDLE_TO - 1);
  localparam logic [TMR_W-1:0]    ACK_LAST  = TMR_W'(ACK_TO - 1);
  localparam logic [TMR_W-1:0]    ERR_LAST  = TMR_W'(ERR_HOLD - 1);
  localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W + 1)'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [2:0]          code_q, code_d;
  logic [3:0]          qty_q, qty_d;
  logic [CREDIT_W-1:0] dpcred_q, dpcred_d;
  logic [2:0]          disp_code_q, disp_code_d;
  logic [3:0]          disp_qty_q, disp_qty_d;
  logic                coin_reject_q, coin_reject_d;
  logic                dp_req_q, dp_req_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                red_light_q, red_light_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W:0]   coin_sum_s;
  logic                coin_open_s;
  logic                coin_ok_s;
  logic [CREDIT_W-1:0] credit_in_s;
  logic                cost_ok_s;

  assign coin_sum_s  = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_open_s = (state_q == S_IDLE) || (state_q == S_COLLECT);
  assign coin_ok_s   = coin_valid && coin_open_s && (coin_sum_s <= MAX_C);
  assign credit_in_s = coin_ok_s ? coin_sum_s[CREDIT_W-1:0] : credit_q;
  assign cost_ok_s   = (dp_cost <= 8'(credit_q));

  // Next-state, datapath latches and registered-output values.
  always_comb begin
    state_d     = state_q;
    credit_d    = credit_in_s;
    timer_d     = timer_q;
    code_d      = code_q;
    qty_d       = qty_q;
    dpcred_d    = dpcred_q;
    disp_code_d = disp_code_q;
    disp_qty_d  = disp_qty_q;

    case (state_q)
      S_IDLE: begin
        if (coin_ok_s) begin
          state_d = S_COLLECT;
          timer_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          state_d = S_CHANGE;
        end else if (sel_valid && (sel_qty != 4'd0)) begin
          code_d   = sel_code;
          qty_d    = sel_qty;
          dpcred_d = credit_in_s;
          state_d  = S_REQ;
        end else if (coin_valid || sel_valid) begin
          timer_d = '0;
        end else if (timer_q == IDLE_LAST) begin
          state_d = S_CHANGE;
        end else begin
          timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (dp_ack) begin
          if (dp_ok && cost_ok_s) begin
            credit_d    = credit_q - dp_cost[CREDIT_W-1:0];
            disp_code_d = code_q;
            disp_qty_d  = qty_q;
            state_d     = S_DISPENSE;
          end else begin
            state_d = S_ERROR;
            timer_d = '0;
          end
        end else if (timer_q == ACK_LAST) begin
          state_d = S_ERROR;
          timer_d = '0;
        end else begin
          timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      S_DISPENSE: begin
        if (credit_q != '0) begin
          state_d = S_CHANGE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHANGE: begin
        if (change_taken) begin
          credit_d = '0;
          state_d  = S_IDLE;
        end else begin
          state_d = S_CHANGE;
        end
      end
      S_ERROR: begin
        if (timer_q == ERR_LAST) begin
          state_d = S_COLLECT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        timer_d  = '0;
      end
    endcase

    coin_reject_d   = coin_valid && !coin_ok_s;
    dp_req_d        = (state_d == S_REQ);
    dispense_d      = (state_d == S_DISPENSE);
    change_valid_d  = (state_d == S_CHANGE);
    change_amount_d = change_valid_d ? credit_d : '0;
    red_light_d     = (state_d == S_ERROR);
    busy_d          = state_d inside {S_REQ, S_WAIT, S_DISPENSE, S_CHANGE, S_ERROR};
  end

  // State, credit, latches and outputs all register together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= '0;
      timer_q         <= '0;
      code_q          <= 3'd0;
      qty_q           <= 4'd0;
      dpcred_q        <= '0;
      disp_code_q     <= 3'd0;
      disp_qty_q      <= 4'd0;
      coin_reject_q   <= 1'b0;
      dp_req_q        <= 1'b0;
      dispense_q      <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
      red_light_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      timer_q         <= timer_d;
      code_q          <= code_d;
      qty_q           <= qty_d;
      dpcred_q        <= dpcred_d;
      disp_code_q     <= disp_code_d;
      disp_qty_q      <= disp_qty_d;
      coin_reject_q   <= coin_reject_d;
      dp_req_q        <= dp_req_d;
      dispense_q      <= dispense_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
      red_light_q     <= red_light_d;
      busy_q          <= busy_d;
    end
  end

  assign coin_reject   = coin_reject_q;
  assign dp_req        = dp_req_q;
  assign dp_code       = code_q;
  assign dp_qty        = qty_q;
  assign dp_credit     = dpcred_q;
  assign dispense      = dispense_q;
  assign dispense_code = disp_code_q;
  assign dispense_qty  = disp_qty_q;
  assign change_valid  = change_valid_q;
  assign change_amount = change_amount_q;
  assign credit        = credit_q;
  assign red_light     = red_light_q;
  assign busy          = busy_q;

endmodule
